// File: rtl/npa_trace_arbiter.sv
// npa_trace_arbiter: round-robin merge of monitor records with timestamps and per-source stall counters
module npa_trace_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int REC_WIDTH = 64,
    parameter int TS_WIDTH = 32,
    localparam int SRC_W = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic                     enable,
    input  logic                     ts_clear,
    input  logic [NUM_SRC-1:0]       src_valid,
    output logic [NUM_SRC-1:0]       src_ready,
    input  logic [NUM_SRC*REC_WIDTH-1:0] src_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [REC_WIDTH-1:0]     out_data,
    output logic [SRC_W-1:0]         out_src,
    output logic [TS_WIDTH-1:0]      out_ts,
    output logic [TS_WIDTH-1:0]      timestamp,
    output logic [NUM_SRC*16-1:0]    stall_cnt,
    output logic                     busy
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_nxt;
    logic run, slot_free, grant, gnt_any;
    logic [SRC_W-1:0] rr, gnt_idx;

    function automatic logic [SRC_W-1:0] wrap_idx(input logic [SRC_W-1:0] base, input int off);
        return SRC_W'((int'(base) + off) % NUM_SRC);
    endfunction

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = enable ? RUN :
                    (state == RUN) ? DRAIN :
                    (state == DRAIN && out_valid && !out_ready) ? DRAIN : IDLE;
    end

    always_comb begin
        busy = state != IDLE;
        run = state == RUN;
    end

    // Scan from farthest to nearest so the nearest valid source after rr wins.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            if (src_valid[wrap_idx(rr, k)]) begin
                gnt_idx = wrap_idx(rr, k);
                gnt_any = 1'b1;
            end
        end
    end

    always_comb begin
        slot_free = !out_valid || out_ready;
        grant = run && slot_free && gnt_any;
        src_ready = grant ? NUM_SRC'(1) << gnt_idx : '0;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            out_valid <= 1'b0;
            out_data <= '0;
            out_src <= '0;
            out_ts <= '0;
            rr <= SRC_W'(NUM_SRC - 1);
        end else if (grant) begin
            out_valid <= 1'b1;
            out_data <= src_data[gnt_idx*REC_WIDTH +: REC_WIDTH];
            out_src <= gnt_idx;
            out_ts <= timestamp;
            rr <= gnt_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) timestamp <= '0;
        else timestamp <= ts_clear ? '0 : timestamp + TS_WIDTH'(1);
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            stall_cnt <= '0;
        end else if (ts_clear) begin
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (src_valid[i] && !src_ready[i] && stall_cnt[i*16 +: 16] != 16'hFFFF)
                    stall_cnt[i*16 +: 16] <= stall_cnt[i*16 +: 16] + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_npa_trace_arbiter.sv
// tb_npa_trace_arbiter: directed and randomized checks of npa_trace_arbiter against a cycle-level reference model
module tb_npa_trace_arbiter;
    localparam int N = 4;
    localparam int RW = 64;
    localparam int TW = 8;
    localparam int SW = 2;

    logic ACLK = 1'b0;
    logic ARESETn = 1'b1;
    logic enable = 1'b0;
    logic ts_clear = 1'b0;
    logic out_ready = 1'b0;
    logic [N-1:0] src_valid = '0;
    logic [N*RW-1:0] src_data = '0;
    logic [N-1:0] src_ready;
    logic out_valid, busy;
    logic [RW-1:0] out_data;
    logic [SW-1:0] out_src;
    logic [TW-1:0] out_ts, timestamp;
    logic [N*16-1:0] stall_cnt;

    int checks = 0;
    int failures = 0;

    int m_state, m_last, m_ts, m_os, m_ots;
    int m_stall[N];
    bit m_ov;
    logic [RW-1:0] m_od;

    npa_trace_arbiter #(.NUM_SRC(N), .REC_WIDTH(RW), .TS_WIDTH(TW)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .enable(enable), .ts_clear(ts_clear),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_src(out_src), .out_ts(out_ts), .timestamp(timestamp),
        .stall_cnt(stall_cnt), .busy(busy)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    // Reference model: mode 0=idle 1=run 2=drain, m_last = last granted source
    task automatic model_reset();
        m_state = 0; m_last = N - 1; m_ts = 0; m_ov = 0; m_od = '0; m_os = 0; m_ots = 0;
        for (int i = 0; i < N; i++) m_stall[i] = 0;
    endtask

    function automatic int model_gnt();
        int g;
        g = -1;
        if (m_state == 1 && (!m_ov || out_ready))
            for (int off = 1; off <= N; off++)
                if (g < 0 && src_valid[(m_last + off) % N]) g = (m_last + off) % N;
        return g;
    endfunction

    function automatic logic [N-1:0] model_rdy();
        int g;
        g = model_gnt();
        return g < 0 ? '0 : N'(1) << g;
    endfunction

    function automatic logic [N*16-1:0] model_stall();
        logic [N*16-1:0] v;
        for (int i = 0; i < N; i++) v[i*16 +: 16] = 16'(m_stall[i]);
        return v;
    endfunction

    task automatic model_update(input int g);
        bit ov_old;
        ov_old = m_ov;
        for (int i = 0; i < N; i++)
            m_stall[i] = ts_clear ? 0 : (src_valid[i] && i != g && m_stall[i] < 65535) ? m_stall[i] + 1 : m_stall[i];
        if (g >= 0) begin
            m_ov = 1; m_od = src_data[g*RW +: RW]; m_os = g; m_ots = m_ts; m_last = g;
        end else if (out_ready) m_ov = 0;
        if (enable) m_state = 1;
        else if (m_state == 1) m_state = 2;
        else if (m_state == 2 && !(ov_old && !out_ready)) m_state = 0;
        m_ts = ts_clear ? 0 : (m_ts + 1) % (1 << TW);
    endtask

    task automatic cycle();
        int g;
        g = model_gnt();
        @(posedge ACLK);
        if (!ARESETn) model_reset();
        else model_update(g);
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) src_data[i*RW +: RW] = {$urandom, $urandom};
    endtask

    task automatic test_reset();
        #1 ARESETn = 1'b0;
        model_reset();
        repeat (2) @(posedge ACLK);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
        checks++; if (timestamp !== '0) begin failures++; $display("FAIL rst_timestamp got=%0h exp=0", timestamp); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy); end
        checks++; if (src_ready !== '0) begin failures++; $display("FAIL rst_src_ready got=%0b exp=0", src_ready); end
        checks++; if (stall_cnt !== '0) begin failures++; $display("FAIL rst_stall got=%0h exp=0", stall_cnt); end
        ARESETn = 1'b1;
        cycle();
        checks++; if (timestamp !== TW'(1)) begin failures++; $display("FAIL rst_ts_count got=%0h exp=1", timestamp); end
    endtask

    task automatic test_round_robin();
        logic [TW-1:0] prev;
        prev = '0;
        enable = 1'b1; src_valid = '1; out_ready = 1'b1; rand_data();
        #1;
        checks++; if (src_ready !== '0) begin failures++; $display("FAIL rr_idle_ready got=%0b exp=0", src_ready); end
        cycle();
        checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL rr_enter_run busy=%0b out_valid=%0b exp=1,0", busy, out_valid); end
        for (int k = 0; k < 8; k++) begin
            rand_data();
            #1;
            checks++; if (src_ready !== N'(1) << (k % N)) begin failures++; $display("FAIL rr_ready k=%0d got=%0b exp=%0b", k, src_ready, N'(1) << (k % N)); end
            cycle();
            checks++; if (out_valid !== 1'b1 || out_src !== SW'(k % N) || out_data !== m_od) begin failures++; $display("FAIL rr_grant k=%0d v=%0b src=%0d data=%0h exp src=%0d data=%0h", k, out_valid, out_src, out_data, k % N, m_od); end
            if (k > 0) begin
                checks++; if (out_ts !== TW'(prev + 1)) begin failures++; $display("FAIL rr_ts k=%0d got=%0h exp=%0h", k, out_ts, TW'(prev + 1)); end
            end
            prev = out_ts;
        end
    endtask

    task automatic test_backpressure();
        logic [RW-1:0] d;
        logic [SW-1:0] s;
        logic [TW-1:0] t;
        logic [N*16-1:0] st;
        out_ready = 1'b0; src_valid = '1;
        #1;
        d = out_data; s = out_src; t = out_ts; st = stall_cnt;
        for (int k = 0; k < 5; k++) begin
            rand_data();
            #1;
            checks++; if (src_ready !== '0) begin failures++; $display("FAIL bp_ready k=%0d got=%0b exp=0", k, src_ready); end
            cycle();
        end
        checks++; if (out_valid !== 1'b1 || out_data !== d || out_src !== s || out_ts !== t) begin failures++; $display("FAIL bp_frozen v=%0b data=%0h src=%0d ts=%0h exp data=%0h src=%0d ts=%0h", out_valid, out_data, out_src, out_ts, d, s, t); end
        for (int i = 0; i < N; i++) begin
            checks++; if (stall_cnt[i*16 +: 16] !== st[i*16 +: 16] + 16'd5) begin failures++; $display("FAIL bp_stall src=%0d got=%0d exp=%0d", i, stall_cnt[i*16 +: 16], st[i*16 +: 16] + 16'd5); end
        end
    endtask

    task automatic test_sparse();
        out_ready = 1'b1; src_valid = 4'b0100; rand_data();
        #1;
        checks++; if (src_ready !== 4'b0100) begin failures++; $display("FAIL sp_ready2 got=%0b exp=0100", src_ready); end
        cycle();
        checks++; if (out_src !== 2'd2 || out_data !== m_od) begin failures++; $display("FAIL sp_grant2 got=%0d exp=2", out_src); end
        src_valid = 4'b1010;
        #1;
        checks++; if (src_ready !== 4'b1000) begin failures++; $display("FAIL sp_ready3 got=%0b exp=1000", src_ready); end
        cycle();
        checks++; if (out_src !== 2'd3) begin failures++; $display("FAIL sp_grant3 got=%0d exp=3", out_src); end
        cycle();
        checks++; if (out_src !== 2'd1) begin failures++; $display("FAIL sp_grant1 got=%0d exp=1", out_src); end
    endtask

    task automatic test_drain();
        out_ready = 1'b0; enable = 1'b0; src_valid = '1;
        cycle();
        checks++; if (busy !== 1'b1 || out_valid !== 1'b1 || out_src !== 2'd1) begin failures++; $display("FAIL dr_enter busy=%0b v=%0b src=%0d exp 1,1,1", busy, out_valid, out_src); end
        #1;
        checks++; if (src_ready !== '0) begin failures++; $display("FAIL dr_ready got=%0b exp=0", src_ready); end
        cycle();
        checks++; if (busy !== 1'b1 || out_valid !== 1'b1 || out_src !== 2'd1) begin failures++; $display("FAIL dr_hold busy=%0b v=%0b src=%0d exp 1,1,1", busy, out_valid, out_src); end
        out_ready = 1'b1;
        #1;
        checks++; if (src_ready !== '0) begin failures++; $display("FAIL dr_ready2 got=%0b exp=0", src_ready); end
        cycle();
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL dr_done busy=%0b v=%0b exp 0,0", busy, out_valid); end
    endtask

    task automatic test_ts_clear();
        int n;
        enable = 1'b1; src_valid = '0; out_ready = 1'b1;
        cycle();
        n = 0;
        while (m_ts != 'h10 && n < 600) begin cycle(); n++; end
        checks++; if (m_ts != 'h10 || busy !== 1'b1) begin failures++; $display("FAIL tc_wait ts=%0h busy=%0b exp 10,1", timestamp, busy); end
        src_valid = 4'b0001; ts_clear = 1'b1; rand_data();
        #1;
        checks++; if (timestamp !== 8'h10 || src_ready !== 4'b0001) begin failures++; $display("FAIL tc_pre ts=%0h ready=%0b exp 10,0001", timestamp, src_ready); end
        cycle();
        ts_clear = 1'b0; src_valid = '0;
        checks++; if (out_valid !== 1'b1 || out_ts !== 8'h10 || out_src !== 2'd0) begin failures++; $display("FAIL tc_rec v=%0b ts=%0h src=%0d exp 1,10,0", out_valid, out_ts, out_src); end
        checks++; if (timestamp !== '0 || stall_cnt !== '0) begin failures++; $display("FAIL tc_clear ts=%0h stall=%0h exp 0,0", timestamp, stall_cnt); end
        n = 0;
        while (m_ts != 255 && n < 600) begin cycle(); n++; end
        checks++; if (timestamp !== 8'hFF) begin failures++; $display("FAIL tc_top got=%0h exp=ff", timestamp); end
        cycle();
        checks++; if (timestamp !== 8'h00) begin failures++; $display("FAIL tc_wrap got=%0h exp=0", timestamp); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            enable = $urandom_range(0, 7) != 0;
            src_valid = N'($urandom);
            out_ready = $urandom_range(0, 3) != 0;
            ts_clear = $urandom_range(0, 31) == 0;
            rand_data();
            #1;
            checks++; if (src_ready !== model_rdy()) begin failures++; $display("FAIL rnd_ready k=%0d got=%0b exp=%0b", k, src_ready, model_rdy()); end
            cycle();
            checks++; if (out_valid !== m_ov || out_data !== m_od || out_src !== SW'(m_os) || out_ts !== TW'(m_ots)) begin failures++; $display("FAIL rnd_out k=%0d v=%0b d=%0h s=%0d t=%0h exp v=%0b d=%0h s=%0d t=%0h", k, out_valid, out_data, out_src, out_ts, m_ov, m_od, m_os, m_ots); end
            checks++; if (timestamp !== TW'(m_ts) || stall_cnt !== model_stall() || busy !== (m_state != 0)) begin failures++; $display("FAIL rnd_state k=%0d ts=%0h stall=%0h busy=%0b exp ts=%0h stall=%0h busy=%0b", k, timestamp, stall_cnt, busy, m_ts, model_stall(), m_state != 0); end
        end
        ts_clear = 1'b0;
    endtask

    task automatic test_async_reset();
        int n;
        enable = 1'b1; src_valid = '1; out_ready = 1'b0;
        n = 0;
        while ((!m_ov || m_state != 1) && n < 8) begin cycle(); n++; end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ar_pre got=%0b exp=1", out_valid); end
        #2 ARESETn = 1'b0;
        #1;
        model_reset();
        checks++; if (out_valid !== 1'b0 || out_data !== '0 || out_src !== '0 || out_ts !== '0) begin failures++; $display("FAIL ar_out v=%0b d=%0h s=%0d t=%0h exp all 0", out_valid, out_data, out_src, out_ts); end
        checks++; if (timestamp !== '0 || stall_cnt !== '0 || busy !== 1'b0 || src_ready !== '0) begin failures++; $display("FAIL ar_state ts=%0h stall=%0h busy=%0b ready=%0b exp all 0", timestamp, stall_cnt, busy, src_ready); end
        cycle();
        ARESETn = 1'b1; out_ready = 1'b1;
        cycle();
        checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL ar_resume v=%0b busy=%0b exp 0,1", out_valid, busy); end
        #1;
        checks++; if (src_ready !== 4'b0001) begin failures++; $display("FAIL ar_first_ready got=%0b exp=0001", src_ready); end
        cycle();
        checks++; if (out_valid !== 1'b1 || out_src !== 2'd0) begin failures++; $display("FAIL ar_first_grant v=%0b src=%0d exp 1,0", out_valid, out_src); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_backpressure();
        test_sparse();
        test_drain();
        test_ts_clear();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
